// File: rtl/multicycle_control_pkg.sv
// multicycle_control_pkg: state, opcode, funct and mux-select encodings shared by the control FSM
package mc_pkg;
  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    EXEC_R   = 4'd2,
    EXEC_I   = 4'd3,
    MEM_ADDR = 4'd4,
    MEM_RD   = 4'd5,
    MEM_WR   = 4'd6,
    WB_ALU   = 4'd7,
    WB_MEM   = 4'd8,
    BRANCH   = 4'd9,
    JAL      = 4'd10,
    TRAP     = 4'd11
  } state_t;
  localparam logic [6:0] OP_R   = 7'd51;
  localparam logic [6:0] OP_I   = 7'd19;
  localparam logic [6:0] OP_LW  = 7'd3;
  localparam logic [6:0] OP_SW  = 7'd35;
  localparam logic [6:0] OP_BR  = 7'd99;
  localparam logic [6:0] OP_JAL = 7'd111;
  localparam logic [2:0] F3_ADD = 3'd0;
  localparam logic [2:0] F3_AND = 3'd7;
  localparam logic [2:0] F3_OR  = 3'd6;
  localparam logic [6:0] F7_BASE = 7'd0;
  localparam logic [6:0] F7_SUB  = 7'd32;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [1:0] PC_ALU    = 2'b00;
  localparam logic [1:0] PC_ALUOUT = 2'b01;
  localparam logic [1:0] A_PC    = 2'b00;
  localparam logic [1:0] A_RS1   = 2'b01;
  localparam logic [1:0] A_OLDPC = 2'b10;
  localparam logic [1:0] B_RS2   = 2'b00;
  localparam logic [1:0] B_FOUR  = 2'b01;
  localparam logic [1:0] B_IMM   = 2'b10;
  localparam logic [1:0] B_BRIMM = 2'b11;
  localparam logic [1:0] WB_ALUOUT = 2'b00;
  localparam logic [1:0] WB_MDR    = 2'b01;
  localparam logic [1:0] WB_PC4    = 2'b10;
endpackage

// File: rtl/multicycle_control_if.sv
// multicycle_control_if: control bundle between the FSM (master) and the datapath/memory (slave)
interface multicycle_control_if;
  logic [31:0] instr;
  logic        mem_ready;
  logic        mem_req;
  logic        mem_we;
  logic        i_or_d;
  logic        ir_write;
  logic        pc_write;
  logic        pc_write_cond;
  logic        branch_ne;
  logic [1:0]  pc_src;
  logic [1:0]  alu_src_a;
  logic [1:0]  alu_src_b;
  logic [2:0]  alu_ctrl;
  logic        reg_write;
  logic [1:0]  mem_to_reg;
  logic        illegal;
  logic [3:0]  state;
  modport master (
    input  instr, mem_ready,
    output mem_req, mem_we, i_or_d, ir_write, pc_write, pc_write_cond, branch_ne,
           pc_src, alu_src_a, alu_src_b, alu_ctrl, reg_write, mem_to_reg, illegal, state
  );
  modport slave (
    output instr, mem_ready,
    input  mem_req, mem_we, i_or_d, ir_write, pc_write, pc_write_cond, branch_ne,
           pc_src, alu_src_a, alu_src_b, alu_ctrl, reg_write, mem_to_reg, illegal, state
  );
endinterface

// File: rtl/multicycle_control_alu_decoder.sv
// alu_decoder: maps funct3/funct7 to an ALU op and flags encodings the ALU cannot execute
module alu_decoder
  import mc_pkg::*;
(
  input  logic       i_r_type,
  input  logic [2:0] i_funct3,
  input  logic [6:0] i_funct7,
  output logic [2:0] o_alu_ctrl,
  output logic       o_funct_illegal
);
  assign o_alu_ctrl = i_funct3 == F3_AND ? ALU_AND
                    : i_funct3 == F3_OR  ? ALU_OR
                    : (i_r_type && i_funct7 == F7_SUB) ? ALU_SUB : ALU_ADD;
  // I-type ignores funct7; R-type only allows sub alongside funct3 add
  assign o_funct_illegal = !(i_funct3 inside {F3_ADD, F3_AND, F3_OR})
                         || (i_r_type && !(i_funct7 == F7_BASE || (i_funct7 == F7_SUB && i_funct3 == F3_ADD)));
endmodule

// File: rtl/multicycle_control.sv
// multicycle_control: FETCH/DECODE/EXECUTE/MEM/WRITEBACK sequencer sharing one memory port
module multicycle_control
  import mc_pkg::*;
#(
  parameter bit SUPPORT_JAL = 1'b1,
  parameter int MEM_TIMEOUT = 16
) (
  input logic clk,
  input logic rstn,
  multicycle_control_if.master bus
);
  localparam int CW = $clog2(MEM_TIMEOUT + 1);
  state_t        r_state;
  state_t        w_next;
  logic [CW-1:0] r_cnt;
  logic [6:0]    w_op;
  logic [2:0]    w_f3;
  logic [6:0]    w_f7;
  logic [2:0]    w_alu_ctrl;
  logic          w_funct_ill;
  logic          w_wait;
  logic          w_timeout;
  assign w_op = bus.instr[6:0];
  assign w_f3 = bus.instr[14:12];
  assign w_f7 = bus.instr[31:25];
  assign w_wait = bus.mem_req && !bus.mem_ready;
  assign w_timeout = w_wait && r_cnt == CW'(MEM_TIMEOUT - 1);
  assign bus.state = r_state;
  alu_decoder u_alu_decoder (
    .i_r_type       (w_op == OP_R),
    .i_funct3       (w_f3),
    .i_funct7       (w_f7),
    .o_alu_ctrl     (w_alu_ctrl),
    .o_funct_illegal(w_funct_ill)
  );
  // next state; a memory wait that runs out overrides everything and TRAP is absorbing
  always_comb begin
    w_next = r_state;
    case (r_state)
      FETCH:    w_next = bus.mem_ready ? DECODE : FETCH;
      DECODE:   w_next = w_op == OP_R ? EXEC_R
                       : w_op == OP_I ? (w_funct_ill ? TRAP : EXEC_I)
                       : (w_op == OP_LW || w_op == OP_SW) ? MEM_ADDR
                       : (w_op == OP_BR && w_f3[2:1] == 2'b00) ? BRANCH
                       : (w_op == OP_JAL && SUPPORT_JAL) ? JAL : TRAP;
      EXEC_R:   w_next = w_funct_ill ? TRAP : WB_ALU;
      EXEC_I:   w_next = WB_ALU;
      MEM_ADDR: w_next = w_op == OP_LW ? MEM_RD : MEM_WR;
      MEM_RD:   w_next = bus.mem_ready ? WB_MEM : MEM_RD;
      MEM_WR:   w_next = bus.mem_ready ? FETCH : MEM_WR;
      WB_ALU, WB_MEM, BRANCH, JAL: w_next = FETCH;
      default:  w_next = TRAP;
    endcase
    if (w_timeout) w_next = TRAP;
  end
  // state register and wait counter, which restarts whenever the state moves
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state <= FETCH;
      r_cnt   <= '0;
    end else begin
      r_state <= w_next;
      r_cnt   <= (w_next != r_state) ? '0 : w_wait ? r_cnt + CW'(1) : r_cnt;
    end
  end
  // Moore outputs per state; FETCH also follows mem_ready and is silenced while in reset
  always_comb begin
    bus.mem_req       = 1'b0;
    bus.mem_we        = 1'b0;
    bus.i_or_d        = 1'b0;
    bus.ir_write      = 1'b0;
    bus.pc_write      = 1'b0;
    bus.pc_write_cond = 1'b0;
    bus.branch_ne     = 1'b0;
    bus.pc_src        = PC_ALU;
    bus.alu_src_a     = A_PC;
    bus.alu_src_b     = B_RS2;
    bus.alu_ctrl      = ALU_ADD;
    bus.reg_write     = 1'b0;
    bus.mem_to_reg    = WB_ALUOUT;
    bus.illegal       = 1'b0;
    case (r_state)
      FETCH: begin
        bus.mem_req   = rstn;
        bus.alu_src_b = B_FOUR;
        bus.ir_write  = rstn && bus.mem_ready;
        bus.pc_write  = rstn && bus.mem_ready;
      end
      DECODE: begin
        bus.alu_src_a = A_OLDPC;
        bus.alu_src_b = B_BRIMM;
      end
      EXEC_R: begin
        bus.alu_src_a = A_RS1;
        bus.alu_ctrl  = w_alu_ctrl;
      end
      EXEC_I: begin
        bus.alu_src_a = A_RS1;
        bus.alu_src_b = B_IMM;
        bus.alu_ctrl  = w_alu_ctrl;
      end
      MEM_ADDR: begin
        bus.alu_src_a = A_RS1;
        bus.alu_src_b = B_IMM;
      end
      MEM_RD: begin
        bus.mem_req = 1'b1;
        bus.i_or_d  = 1'b1;
      end
      MEM_WR: begin
        bus.mem_req = 1'b1;
        bus.mem_we  = 1'b1;
        bus.i_or_d  = 1'b1;
      end
      WB_ALU: bus.reg_write = 1'b1;
      WB_MEM: begin
        bus.reg_write  = 1'b1;
        bus.mem_to_reg = WB_MDR;
      end
      BRANCH: begin
        bus.alu_src_a     = A_RS1;
        bus.alu_ctrl      = ALU_SUB;
        bus.pc_write_cond = 1'b1;
        bus.branch_ne     = w_f3[0];
        bus.pc_src        = PC_ALUOUT;
      end
      JAL: begin
        bus.reg_write  = 1'b1;
        bus.mem_to_reg = WB_PC4;
        bus.pc_write   = 1'b1;
        bus.pc_src     = PC_ALUOUT;
      end
      TRAP: bus.illegal = 1'b1;
      default: ;
    endcase
  end
endmodule

// File: tb/tb_multicycle_control.sv
// tb_multicycle_control: random instruction stream against a per-instruction sequence model, scoreboarded per cycle
module tb_multicycle_control;
  localparam int TO = 16;
  localparam int S_FETCH = 0, S_DECODE = 1, S_EXEC_R = 2, S_EXEC_I = 3, S_MEM_ADDR = 4, S_MEM_RD = 5;
  localparam int S_MEM_WR = 6, S_WB_ALU = 7, S_WB_MEM = 8, S_BRANCH = 9, S_JAL = 10, S_TRAP = 11;
  typedef struct packed {
    logic [3:0] st;
    logic       req, we, iod, irw, pcw, pcc, bne;
    logic [1:0] pcs, sa, sb;
    logic [2:0] alu;
    logic       rw;
    logic [1:0] m2r;
    logic       ill;
  } exp_t;
  logic clk = 1'b0;
  logic rst1, rst0, mem_ready;
  logic [31:0] instr;
  int n_chk = 0;
  int n_fail = 0;
  exp_t q1[$];
  exp_t q0[$];
  exp_t s1, s0;
  multicycle_control_if b1 ();
  multicycle_control_if b0 ();
  assign b1.instr = instr;
  assign b1.mem_ready = mem_ready;
  assign b0.instr = instr;
  assign b0.mem_ready = mem_ready;
  multicycle_control #(.SUPPORT_JAL(1'b1), .MEM_TIMEOUT(TO)) dut1 (.clk(clk), .rstn(rst1), .bus(b1));
  multicycle_control #(.SUPPORT_JAL(1'b0), .MEM_TIMEOUT(TO)) dut0 (.clk(clk), .rstn(rst0), .bus(b0));
  assign s1 = {b1.state, b1.mem_req, b1.mem_we, b1.i_or_d, b1.ir_write, b1.pc_write, b1.pc_write_cond,
               b1.branch_ne, b1.pc_src, b1.alu_src_a, b1.alu_src_b, b1.alu_ctrl, b1.reg_write,
               b1.mem_to_reg, b1.illegal};
  assign s0 = {b0.state, b0.mem_req, b0.mem_we, b0.i_or_d, b0.ir_write, b0.pc_write, b0.pc_write_cond,
               b0.branch_ne, b0.pc_src, b0.alu_src_a, b0.alu_src_b, b0.alu_ctrl, b0.reg_write,
               b0.mem_to_reg, b0.illegal};
  always #5 clk = ~clk;

  task automatic check(input string nm, input exp_t got, input exp_t exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s state=%0d: got %h expected %h", nm, exp.st, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (q1.size() != 0) check("jal_on", s1, q1.pop_front());
    if (q0.size() != 0) check("jal_off", s0, q0.pop_front());
  end

  function automatic logic rb();
    return 1'($urandom_range(0, 1));
  endfunction

  function automatic logic [2:0] alu_of(input logic [31:0] i);
    return i[14:12] == 3'd7 ? 3'b000 : i[14:12] == 3'd6 ? 3'b001
         : (i[6:0] == 7'd51 && i[31:25] == 7'd32) ? 3'b110 : 3'b010;
  endfunction

  function automatic exp_t out_of(input int st, input logic rdy, input logic [31:0] i);
    exp_t e = '0;
    e.st = 4'(st);
    e.alu = 3'b010;
    case (st)
      S_FETCH:    begin e.req = 1; e.sb = 2'b01; e.irw = rdy; e.pcw = rdy; end
      S_DECODE:   begin e.sa = 2'b10; e.sb = 2'b11; end
      S_EXEC_R:   begin e.sa = 2'b01; e.alu = alu_of(i); end
      S_EXEC_I:   begin e.sa = 2'b01; e.sb = 2'b10; e.alu = alu_of(i); end
      S_MEM_ADDR: begin e.sa = 2'b01; e.sb = 2'b10; end
      S_MEM_RD:   begin e.req = 1; e.iod = 1; end
      S_MEM_WR:   begin e.req = 1; e.we = 1; e.iod = 1; end
      S_WB_ALU:   e.rw = 1;
      S_WB_MEM:   begin e.rw = 1; e.m2r = 2'b01; end
      S_BRANCH:   begin e.sa = 2'b01; e.alu = 3'b110; e.pcc = 1; e.bne = i[12]; e.pcs = 2'b01; end
      S_JAL:      begin e.rw = 1; e.m2r = 2'b10; e.pcw = 1; e.pcs = 2'b01; end
      S_TRAP:     e.ill = 1;
      default: ;
    endcase
    return e;
  endfunction

  function automatic exp_t rst_rec();
    exp_t e = out_of(S_FETCH, 1'b0, '0);
    e.req = 1'b0;
    return e;
  endfunction

  task automatic step(input int st, input logic rdy, input logic [31:0] i, input bit w);
    mem_ready = rdy;
    instr = (st == S_FETCH) ? $urandom : i;
    if (w) q1.push_back(out_of(st, rdy, i));
    else q0.push_back(out_of(st, rdy, i));
    @(posedge clk);
    #1;
  endtask

  task automatic mem_phase(input int st, input int wt, input logic [31:0] i, input bit w, output bit trapped);
    trapped = 1;
    for (int k = 0; k < TO; k++) begin
      step(st, k >= wt, i, w);
      if (k >= wt) begin
        trapped = 0;
        break;
      end
    end
  endtask

  task automatic trap_and_reset(input logic [31:0] i, input int hold, input bit w);
    for (int k = 0; k < hold; k++) step(S_TRAP, rb(), i, w);
    mem_ready = 1'b0;
    #2;
    if (w) rst1 = 1'b0;
    else rst0 = 1'b0;
    #1;
    check("async_reset", w ? s1 : s0, rst_rec());
    @(posedge clk);
    #1;
    if (w) rst1 = 1'b1;
    else rst0 = 1'b1;
  endtask

  task automatic run_instr(input logic [31:0] i, input int fw, input int mw, input bit w, input bit sj, input int hold);
    bit t, ok;
    logic [6:0] op, f7;
    logic [2:0] f3;
    op = i[6:0];
    f3 = i[14:12];
    f7 = i[31:25];
    mem_phase(S_FETCH, fw, i, w, t);
    if (t) begin
      trap_and_reset(i, hold, w);
      return;
    end
    step(S_DECODE, rb(), i, w);
    ok = 1;
    if (op == 7'd51) begin
      step(S_EXEC_R, rb(), i, w);
      ok = (f7 == 7'd0 && f3 inside {3'd0, 3'd6, 3'd7}) || (f7 == 7'd32 && f3 == 3'd0);
      if (ok) step(S_WB_ALU, rb(), i, w);
    end else if (op == 7'd19) begin
      ok = f3 inside {3'd0, 3'd6, 3'd7};
      if (ok) begin
        step(S_EXEC_I, rb(), i, w);
        step(S_WB_ALU, rb(), i, w);
      end
    end else if (op == 7'd3 || op == 7'd35) begin
      step(S_MEM_ADDR, rb(), i, w);
      mem_phase(op == 7'd3 ? S_MEM_RD : S_MEM_WR, mw, i, w, t);
      ok = !t;
      if (ok && op == 7'd3) step(S_WB_MEM, rb(), i, w);
    end else if (op == 7'd99) begin
      ok = f3 < 3'd2;
      if (ok) step(S_BRANCH, rb(), i, w);
    end else if (op == 7'd111 && sj) step(S_JAL, rb(), i, w);
    else ok = 0;
    if (!ok) trap_and_reset(i, hold, w);
  endtask

  function automatic logic [31:0] rand_ins();
    logic [31:0] r;
    r = $urandom;
    case ($urandom_range(0, 8))
      0, 1: begin
        r[6:0] = 7'd51;
        case ($urandom_range(0, 3))
          0: {r[31:25], r[14:12]} = {7'd0, 3'd0};
          1: {r[31:25], r[14:12]} = {7'd32, 3'd0};
          2: {r[31:25], r[14:12]} = {7'd0, 3'd7};
          default: {r[31:25], r[14:12]} = {7'd0, 3'd6};
        endcase
      end
      2, 3: r[6:0] = 7'd19;
      4: r[6:0] = 7'd3;
      5: r[6:0] = 7'd35;
      6: begin
        r[6:0] = 7'd99;
        r[14:12] = 3'($urandom_range(0, 3));
      end
      7: r[6:0] = 7'd111;
      default: ;
    endcase
    return r;
  endfunction

  function automatic int wait_of();
    return $urandom_range(0, 9) == 0 ? int'($urandom_range(TO - 2, TO + 1)) : int'($urandom_range(0, 2));
  endfunction

  initial begin
    rst1 = 1'b1;
    rst0 = 1'b1;
    mem_ready = 1'b0;
    instr = '0;
    #1;
    rst1 = 1'b0;
    rst0 = 1'b0;
    @(posedge clk);
    #1;
    for (int k = 0; k < 2; k++) begin
      q1.push_back(rst_rec());
      q0.push_back(rst_rec());
      @(posedge clk);
      #1;
    end
    rst1 = 1'b1;
    run_instr(32'h002081B3, 0, 0, 1, 1, 2);
    run_instr(32'h0000A183, 0, 3, 1, 1, 2);
    run_instr(32'h00209463, 1, 0, 1, 1, 2);
    run_instr(32'h00208463, 0, 0, 1, 1, 2);
    run_instr(32'h0000006F, 0, 0, 1, 1, 2);
    run_instr(32'h00000013, TO, 0, 1, 1, 2);
    run_instr(32'h00000013, TO - 1, 0, 1, 1, 2);
    run_instr(32'h0020A023, 0, TO, 1, 1, 2);
    run_instr(32'h0000A183, 0, TO - 1, 1, 1, 2);
    run_instr(32'h022081B3, 0, 0, 1, 1, 100);
    repeat (250) run_instr(rand_ins(), wait_of(), wait_of(), 1, 1, 1 + int'($urandom_range(0, 3)));
    rst1 = 1'b0;
    mem_ready = 1'b0;
    q0.push_back(rst_rec());
    @(posedge clk);
    #1;
    rst0 = 1'b1;
    run_instr(32'h0000006F, 0, 0, 0, 0, 3);
    repeat (40) run_instr(rand_ins(), wait_of(), wait_of(), 0, 0, 2);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
